// File: rtl/photon_pulse_counter.sv
// Gated photon pulse counter: counts synchronized rising edges of ex_pulse per gate
// and converts each gate total to packed BCD with a one-shift-per-cycle double-dabble FSM.

module photon_bcd_adj3 (
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);
    assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

module photon_pulse_counter #(
    parameter int GATE_CYCLES = 20_000_000,
    parameter int CNT_W       = 24,
    parameter int DIGITS      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_pulse,
    input  logic                en,
    output logic                gate_tick,
    output logic [CNT_W-1:0]    count_bin,
    output logic                overflow,
    output logic [4*DIGITS-1:0] bcd,
    output logic                valid
);
    localparam int GCW = $clog2(GATE_CYCLES);
    localparam int DW  = 4 * DIGITS;
    localparam int SCW = $clog2(CNT_W + 1);
    localparam logic [GCW-1:0] GATE_LAST = GCW'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE} bcd_state_e;

    logic [2:0]       sync_q, sync_d;
    logic             pulse_edge;
    logic             tick;
    logic [GCW-1:0]   gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0] acc_q, acc_d, acc_next;
    logic             sat_q, sat_d, sat_next;
    logic [CNT_W-1:0] count_bin_q, count_bin_d;
    logic             overflow_q, overflow_d;

    bcd_state_e       state_q;
    logic [CNT_W-1:0] bin_sr_q;
    logic [DW-1:0]    scratch_q, scratch_adj, scratch_shl;
    logic [SCW-1:0]   shift_cnt_q;
    logic [DW-1:0]    bcd_q;
    logic             valid_q;
    logic             unused_adj_msb;

    // sync_q[1] is the second synchronizer stage; sync_q[2] is its delayed copy.
    assign pulse_edge = sync_q[1] & ~sync_q[2];
    assign tick       = en & (gate_cnt_q == GATE_LAST);

    // An edge arriving while already at full scale is the one that marks the gate saturated.
    assign acc_next = (pulse_edge && !(&acc_q)) ? acc_q + CNT_W'(1) : acc_q;
    assign sat_next = sat_q | (pulse_edge & (&acc_q));

    always_comb begin
        sync_d      = {sync_q[1:0], ex_pulse};
        gate_cnt_d  = gate_cnt_q;
        acc_d       = acc_q;
        sat_d       = sat_q;
        count_bin_d = count_bin_q;
        overflow_d  = overflow_q;
        if (!en) begin
            gate_cnt_d = '0;
            acc_d      = '0;
            sat_d      = 1'b0;
        end else if (tick) begin
            gate_cnt_d  = '0;
            acc_d       = '0;
            sat_d       = 1'b0;
            count_bin_d = acc_next;
            overflow_d  = sat_next;
        end else begin
            gate_cnt_d = gate_cnt_q + GCW'(1);
            acc_d      = acc_next;
            sat_d      = sat_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= '0;
            gate_cnt_q  <= '0;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            count_bin_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            gate_cnt_q  <= gate_cnt_d;
            acc_q       <= acc_d;
            sat_q       <= sat_d;
            count_bin_q <= count_bin_d;
            overflow_q  <= overflow_d;
        end
    end

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            photon_bcd_adj3 u_adj (
                .d_i (scratch_q[4*g +: 4]),
                .d_o (scratch_adj[4*g +: 4])
            );
        end
    endgenerate

    // The digit-count constraint keeps the top adjusted bit clear, so dropping it is safe.
    assign scratch_shl    = {scratch_adj[DW-2:0], bin_sr_q[CNT_W-1]};
    assign unused_adj_msb = scratch_adj[DW-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bin_sr_q    <= '0;
            scratch_q   <= '0;
            shift_cnt_q <= '0;
            bcd_q       <= '0;
            valid_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (tick) state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    bin_sr_q    <= count_bin_q;
                    scratch_q   <= '0;
                    shift_cnt_q <= SCW'(CNT_W);
                    state_q     <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    scratch_q   <= scratch_shl;
                    bin_sr_q    <= {bin_sr_q[CNT_W-2:0], 1'b0};
                    shift_cnt_q <= shift_cnt_q - SCW'(1);
                    // Publish on the last shift so bcd/valid are visible during DONE.
                    if (shift_cnt_q == SCW'(1)) begin
                        bcd_q   <= scratch_shl;
                        valid_q <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign gate_tick = tick;
    assign count_bin = count_bin_q;
    assign overflow  = overflow_q;
    assign bcd       = bcd_q;
    assign valid     = valid_q;

endmodule

// File: doc/photon_pulse_counter.md
# photon_pulse_counter

Counts rising edges of the external photon pulse input over a fixed gate time and publishes each gate's total as binary and packed BCD for the TFT display path. It sits on the receive side of the on-board 1 Hz test pulse, which is looped back to the photon input. It runs in the 20 MHz PLL domain and replaces ad-hoc counting inside the display adapter. The display side samples `bcd` whenever `valid` pulses.

## Interface
- `GATE_CYCLES`, default 20_000_000: gate length in clk cycles (1 s at 20 MHz); must be ≥ `CNT_W`+4.
- `CNT_W`, default 24: accumulator and `count_bin` width.
- `DIGITS`, default 8: BCD digit count; must satisfy 2^`CNT_W`−1 ≤ 10^`DIGITS`−1.

Ports:
- `clk`, in, 1: single clock (20 MHz PLL output).
- `rst`, in, 1: asynchronous, active-high reset.
- `ex_pulse`, in, 1: asynchronous photon pulse pin.
- `en`, in, 1: gate enable.
- `gate_tick`, out, 1: one-cycle strobe on the last cycle of each gate.
- `count_bin`, out, `CNT_W`: count from the last completed gate.
- `overflow`, out, 1: the last completed gate saturated.
- `bcd`, out, 4×`DIGITS`: packed BCD of `count_bin`; digit 0 is in bits [3:0].
- `valid`, out, 1: one-cycle strobe; `bcd` is updated in the same cycle.

## Operation
- **Input path:** two-flop synchronizer, then a third flop. `edge` = sync2 & ~sync3.
- **Pulse width:** `ex_pulse` high and low phases must each be ≥ 2 clk cycles. Shorter pulses are not guaranteed to count.
- **Gate counter:** counts 0..`GATE_CYCLES`−1. `gate_tick` = (gate counter == `GATE_CYCLES`−1) & `en`.
- **Accumulator:**
  - Increments on `edge`.
  - Saturates at 2^`CNT_W`−1 and sets a per-gate `sat` flag.
  - On `gate_tick`: accumulator value (including an edge in that cycle) → `count_bin`, `sat` → `overflow`. The accumulator then restarts at 0.
  - Edge on the tick cycle: it is included in the closing gate (the same-cycle increment is taken before latching).
- **`en` low:**
  - Gate counter, accumulator and `sat` are held at 0. No `gate_tick`.
  - `count_bin`, `overflow` and `bcd` retain their values.
  - When `en` rises, a full fresh gate starts.
- **BCD converter FSM** (double-dabble, one shift per cycle):
  - IDLE: on `gate_tick` go to LOAD.
  - LOAD (1 cycle): capture `count_bin`, clear the scratch register, load shift count = `CNT_W`.
  - SHIFT (`CNT_W` cycles): add 3 to every digit ≥ 5, then shift left 1.
  - DONE (1 cycle): write `bcd`, assert `valid`, go to IDLE.
  - The `GATE_CYCLES` constraint guarantees a `gate_tick` never arrives outside IDLE. Such a tick is not required to be handled.
- **Reset values:**
  - All outputs 0; FSM in IDLE; synchronizer flops 0.
  - Reset during conversion aborts it: `bcd` = 0 and no `valid` pulse.

## Timing
- `ex_pulse` rising at a clk edge → accumulator increment visible 3 cycles later.
- `gate_tick` in cycle T → `count_bin`/`overflow` update at T+1.
- LOAD occupies T+1, SHIFT T+2..T+`CNT_W`+1, DONE at T+`CNT_W`+2. `bcd` and `valid` update at T+`CNT_W`+2.
- `count_bin` stays stable from T+1 until the next gate's tick+1.
- `gate_tick` period is exactly `GATE_CYCLES` while `en` stays high.
- `en` deasserted on the tick cycle: no tick is issued and no result is produced for that gate.

## Test plan
- **Reset:** assert `rst` mid-run → all outputs 0 immediately. After release, the first `gate_tick` comes `GATE_CYCLES` cycles after `en` is seen high.
- **Basic count** (`GATE_CYCLES`=100, `CNT_W`=8, `DIGITS`=3): 10 pulses, 4 high / 4 low, in one gate.
  - Expect `count_bin`=10, `overflow`=0.
  - Expect `bcd`=12'h010 with `valid` high for 1 cycle at tick+10.
- **Saturation** (`GATE_CYCLES`=100, `CNT_W`=4, `DIGITS`=2): 20 pulses in one gate.
  - Expect `count_bin`=15, `overflow`=1, `bcd`=8'h15.
  - Next gate with 3 pulses: expect `count_bin`=3, `overflow`=0.
- **Boundary edge:** time a synchronized edge to land exactly on the `gate_tick` cycle, with 5 earlier pulses in the gate.
  - Closing gate reports 6.
  - Next gate with no pulses reports 0.
- **Enable drop:** drop `en` at cycle 50 of a gate and hold it low for 300 cycles.
  - No `gate_tick`; `count_bin` and `bcd` unchanged.
  - Re-enable with 7 pulses: reported 7 exactly 100 cycles after `en` rises.
- **Reset mid-conversion:** assert `rst` 3 cycles after `gate_tick`.
  - No `valid`; `bcd`=0; FSM in IDLE.
  - Next full gate converts correctly.
